// File: rtl/chk_pkg.sv
// chk_pkg: definitions shared by the check engine and the stimulus block.
//   - side-channel command codes (sc_cmd)
//   - check engine FSM state encoding
//   - log record word indices and the fail-flag bit position in word 0
package chk_pkg;

  // Side-channel command codes, shared with the stimulus generator.
  localparam logic [4:0] SC_CMD_IDLE    = 5'b00000;
  localparam logic [4:0] SC_CMD_BITMASK = 5'b00001;

  // Check engine states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_WR0     = 3'd2,
    ST_WR1     = 3'd3,
    ST_WR2     = 3'd4,
    ST_WR3     = 3'd5
  } state_t;

  // Log record layout: four 16-bit words per record.
  localparam logic [1:0] REC_W0    = 2'd0;
  localparam logic [1:0] REC_W1    = 2'd1;
  localparam logic [1:0] REC_W2    = 2'd2;
  localparam logic [1:0] REC_W3    = 2'd3;
  localparam int         REC_WORDS = 4;

  // Position of the mismatch flag inside record word 0.
  localparam int FAIL_BIT = 15;

endpackage

// File: rtl/check_engine.sv
// check_engine: pairs expected-result records from CHECK_FIFO with DUT result
// words from RESULT_FIFO, compares them under a programmable bitmask and logs
// records into SRAM through an Avalon-MM write master.
//
// Ports:
//   clock, reset_n          single clock, asynchronous active-low reset
//   clear                   pulse (honoured in IDLE): zero counter, rewind log,
//                           drop overflow flag, restore all-ones bitmask
//   done                    idle with both FIFOs empty
//   cfifo_*                 CHECK_FIFO read side (show-ahead): {expected, tag}
//   rfifo_*                 RESULT_FIFO read side (show-ahead): actual result
//   sc_cmd, sc_data,        side channel from the stimulus block (bitmask setup)
//   sc_ready
//   mem_*                   Avalon-MM write master towards the log SRAM
//   fail_count              saturating mismatch counter
//   log_overflow            set when a record was dropped because the log is full
//
// Build option: define CHK_LOG_PASS_EN to also log passing vectors (fail=0).
// Without it only mismatches are written to the log.
//
// The record layout assumes DATA_WIDTH=16, ADDR_WIDTH>=20 and STF_WIDTH>=24.
module check_engine
  import chk_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    STF_WIDTH   = 24,
  parameter int                    CHF_WIDTH   = STF_WIDTH + ADDR_WIDTH,
  parameter int                    SCC_WIDTH   = 5,
  parameter int                    SCD_WIDTH   = 24,
  parameter logic [ADDR_WIDTH-1:0] LOG_BASE    = 20'h80000,
  parameter int                    LOG_RECORDS = 4096,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  output logic                    done,
  input  logic [CHF_WIDTH-1:0]    cfifo_data,
  output logic                    cfifo_rdreq,
  input  logic                    cfifo_rdempty,
  input  logic [STF_WIDTH-1:0]    rfifo_data,
  output logic                    rfifo_rdreq,
  input  logic                    rfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]    sc_cmd,
  input  logic [SCD_WIDTH-1:0]    sc_data,
  output logic                    sc_ready,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_writedata,
  input  logic                    mem_waitrequest,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic                    log_overflow
);

  // One past the last log word; the pointer stops here and never wraps.
  localparam logic [ADDR_WIDTH-1:0] LOG_END =
    LOG_BASE + ADDR_WIDTH'(REC_WORDS * LOG_RECORDS);

  state_t                  state_r;
  logic [STF_WIDTH-1:0]    bitmask_r;
  logic [ADDR_WIDTH-1:0]   log_ptr_r;
  logic [STF_WIDTH-1:0]    expected_r;
  logic [STF_WIDTH-1:0]    actual_r;
  logic [ADDR_WIDTH-1:0]   tag_r;
  logic                    fail_r;

  logic                    idle_s;
  logic                    pop_s;
  logic [STF_WIDTH-1:0]    mism_s;
  logic                    mism_any_s;
  logic                    log_req_s;
  logic                    log_full_s;
  logic [1:0]              wr_idx_s;
  logic [1:0]              wr_next_idx_s;
  state_t                  wr_next_state_s;

  // Build one 16-bit word of a log record.
  function automatic logic [DATA_WIDTH-1:0] record_word(
    input logic [1:0]            idx,
    input logic                  fail,
    input logic [ADDR_WIDTH-1:0] tag,
    input logic [STF_WIDTH-1:0]  actual
  );
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    case (idx)
      REC_W0: begin
        w[FAIL_BIT] = fail;
        w[3:0]      = tag[19:16];
      end
      REC_W1:  w      = tag[15:0];
      REC_W2:  w[7:0] = actual[23:16];
      REC_W3:  w      = actual[15:0];
      default: w      = '0;
    endcase
    return w;
  endfunction

  assign mem_byteenable = {(DATA_WIDTH/8){1'b1}};

  // Handshake outputs decoded from the current state and FIFO/side-channel inputs.
  always_comb begin
    idle_s = (state_r == ST_IDLE);
    // clear and a bitmask command take the IDLE cycle; no pop alongside them.
    pop_s  = idle_s && !clear && (sc_cmd != SCC_WIDTH'(SC_CMD_BITMASK))
             && !cfifo_rdempty && !rfifo_rdempty;
    sc_ready    = idle_s;
    cfifo_rdreq = pop_s;
    rfifo_rdreq = pop_s;
    done        = idle_s && cfifo_rdempty && rfifo_rdempty;
  end

  // Compare result and logging decision for the vector held in COMPARE.
  always_comb begin
    mism_s     = (actual_r ^ expected_r) & bitmask_r;
    mism_any_s = |mism_s;
    log_full_s = (log_ptr_r == LOG_END);
`ifdef CHK_LOG_PASS_EN
    log_req_s  = 1'b1;
`else
    log_req_s  = mism_any_s;
`endif
  end

  // Word index of the write in flight and the state that follows it.
  always_comb begin
    wr_idx_s        = REC_W0;
    wr_next_state_s = ST_IDLE;
    case (state_r)
      ST_WR0: begin
        wr_idx_s        = REC_W0;
        wr_next_state_s = ST_WR1;
      end
      ST_WR1: begin
        wr_idx_s        = REC_W1;
        wr_next_state_s = ST_WR2;
      end
      ST_WR2: begin
        wr_idx_s        = REC_W2;
        wr_next_state_s = ST_WR3;
      end
      ST_WR3: begin
        wr_idx_s        = REC_W3;
        wr_next_state_s = ST_IDLE;
      end
      default: begin
        wr_idx_s        = REC_W0;
        wr_next_state_s = ST_IDLE;
      end
    endcase
    wr_next_idx_s = wr_idx_s + 2'd1;
  end

  // Main FSM: pop, compare, count and serialize the 4-word record.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      bitmask_r     <= '1;
      log_ptr_r     <= LOG_BASE;
      expected_r    <= '0;
      actual_r      <= '0;
      tag_r         <= '0;
      fail_r        <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= LOG_BASE;
      mem_writedata <= '0;
      fail_count    <= '0;
      log_overflow  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear) begin
            fail_count   <= '0;
            log_ptr_r    <= LOG_BASE;
            mem_address  <= LOG_BASE;
            log_overflow <= 1'b0;
            bitmask_r    <= '1;
          end else if (sc_cmd == SCC_WIDTH'(SC_CMD_BITMASK)) begin
            bitmask_r <= STF_WIDTH'(sc_data);
          end else if (pop_s) begin
            expected_r <= cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
            tag_r      <= cfifo_data[ADDR_WIDTH-1:0];
            actual_r   <= rfifo_data;
            state_r    <= ST_COMPARE;
          end
        end

        ST_COMPARE: begin
          fail_r <= mism_any_s;
          if (mism_any_s && (fail_count != {CNT_WIDTH{1'b1}})) begin
            fail_count <= fail_count + CNT_WIDTH'(1);
          end
          if (log_req_s && !log_full_s) begin
            state_r       <= ST_WR0;
            mem_write     <= 1'b1;
            mem_address   <= log_ptr_r;
            mem_writedata <= record_word(REC_W0, mism_any_s, tag_r, actual_r);
          end else if (log_req_s) begin
            log_overflow <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        // Outputs hold while the slave stalls; advance only on acceptance.
        ST_WR0, ST_WR1, ST_WR2: begin
          if (!mem_waitrequest) begin
            state_r       <= wr_next_state_s;
            mem_address   <= log_ptr_r + ADDR_WIDTH'(wr_next_idx_s);
            mem_writedata <= record_word(wr_next_idx_s, fail_r, tag_r, actual_r);
          end
        end

        ST_WR3: begin
          if (!mem_waitrequest) begin
            state_r       <= ST_IDLE;
            mem_write     <= 1'b0;
            log_ptr_r     <= log_ptr_r + ADDR_WIDTH'(REC_WORDS);
            mem_address   <= log_ptr_r + ADDR_WIDTH'(REC_WORDS);
            mem_writedata <= '0;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_check_engine.sv
// tb_check_engine: self-checking bench for check_engine. Show-ahead FIFOs and
// the Avalon slave are modelled with queues; a record-level reference model
// predicts every SRAM write, the fail counter and the overflow flag.
module tb_check_engine;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int SW   = 24;
  localparam int CW   = SW + AW;
  localparam int CNTW = 16;
  localparam int LR   = 2;
  localparam logic [AW-1:0] BASE = 20'h80000;
`ifdef CHK_LOG_PASS_EN
  localparam bit LOG_PASS = 1'b1;
`else
  localparam bit LOG_PASS = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n;
  logic            clear;
  logic            done;
  logic [CW-1:0]   cfifo_data;
  logic            cfifo_rdreq;
  logic            cfifo_rdempty;
  logic [SW-1:0]   rfifo_data;
  logic            rfifo_rdreq;
  logic            rfifo_rdempty;
  logic [4:0]      sc_cmd;
  logic [23:0]     sc_data;
  logic            sc_ready;
  logic [AW-1:0]   mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic            mem_write;
  logic [DW-1:0]   mem_writedata;
  logic            mem_waitrequest;
  logic [CNTW-1:0] fail_count;
  logic            log_overflow;

  always #5 clock = ~clock;

  check_engine #(.LOG_RECORDS(LR)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .done(done),
    .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .rfifo_data(rfifo_data), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .fail_count(fail_count), .log_overflow(log_overflow)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            last_pop_cycle = -1;
  logic [CW-1:0] cq[$];
  logic [SW-1:0] rq[$];
  wr_t           wr_seen[$];
  wr_t           exp_wr[$];
  int            stall_cnt = 0;
  logic [AW-1:0] stall_addr = '0;
  bit            rand_en = 1'b0;

  // reference model state
  logic [SW-1:0] m_mask;
  int            m_fc;
  int            m_rec;
  bit            m_ovf;

  task automatic model_clear();
    m_mask = '1;
    m_fc   = 0;
    m_rec  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic drive_fifo();
    cfifo_rdempty = (cq.size() == 0);
    rfifo_rdempty = (rq.size() == 0);
    cfifo_data    = (cq.size() > 0) ? cq[0] : '0;
    rfifo_data    = (rq.size() > 0) ? rq[0] : '0;
  endtask

  task automatic push_vec(input logic [SW-1:0] e, input logic [SW-1:0] a, input logic [AW-1:0] t);
    cq.push_back({e, t});
    rq.push_back(a);
    drive_fifo();
  endtask

  // One popped vector: decide pass/fail and predict the record writes.
  task automatic model_pop();
    logic [CW-1:0] c;
    logic [SW-1:0] a;
    logic [SW-1:0] e;
    logic [AW-1:0] t;
    bit            fail;
    logic [DW-1:0] w[4];
    c = cq.pop_front();
    a = rq.pop_front();
    e = c[CW-1 -: SW];
    t = c[AW-1:0];
    fail = (((a ^ e) & m_mask) != '0);
    if (fail && m_fc < 65535) m_fc++;
    if (fail || LOG_PASS) begin
      if (m_rec < LR) begin
        w[0] = {fail, 11'b0, t[19:16]};
        w[1] = t[15:0];
        w[2] = {8'b0, a[23:16]};
        w[3] = a[15:0];
        for (int k = 0; k < 4; k++)
          exp_wr.push_back('{addr: BASE + AW'(4 * m_rec + k), data: w[k], cyc: 0});
        m_rec++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Advance one clock: sample at the edge, then update FIFOs/slave at +1.
  task automatic tick();
    logic          pop_c;
    logic          pop_r;
    logic          wv;
    logic          wq;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    @(posedge clock);
    pop_c = cfifo_rdreq;
    pop_r = rfifo_rdreq;
    wv    = mem_write;
    wq    = mem_waitrequest;
    pa    = mem_address;
    pd    = mem_writedata;
    cycle++;
    if (pop_c === 1'b1 || pop_r === 1'b1) begin
      checks++;
      if (pop_c !== pop_r || cq.size() == 0 || rq.size() == 0) begin
        errors++;
        $display("FAIL rdreq_pair: cfifo_rdreq=%b rfifo_rdreq=%b cq=%0d rq=%0d, required both high with data", pop_c, pop_r, cq.size(), rq.size());
      end
    end
    if (wv === 1'b1 && wq === 1'b0) wr_seen.push_back('{addr: pa, data: pd, cyc: cycle});
    #1;
    if (pop_c === 1'b1 && pop_r === 1'b1 && cq.size() > 0 && rq.size() > 0) begin
      model_pop();
      last_pop_cycle = cycle;
    end
    drive_fifo();
    if (wv === 1'b1 && wq === 1'b1 && reset_n === 1'b1) begin
      checks++;
      if (mem_write !== 1'b1 || mem_address !== pa || mem_writedata !== pd) begin
        errors++;
        $display("FAIL hold_stable: write=%b addr=%h data=%h, required 1 %h %h", mem_write, mem_address, mem_writedata, pa, pd);
      end
    end
    if (stall_cnt > 0 && mem_write === 1'b1 && mem_address === stall_addr) begin
      mem_waitrequest = 1'b1;
      stall_cnt--;
    end else if (rand_en) begin
      mem_waitrequest = ($urandom_range(0, 2) == 0);
    end else begin
      mem_waitrequest = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(done === 1'b1 && cq.size() == 0) && n < budget);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (sc_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_clear();
    wait_ready();
    clear = 1'b1;
    model_clear();
    tick();
    clear = 1'b0;
  endtask

  // Drain observed writes against the model and compare counter/flag.
  task automatic check_writes(input string name);
    wr_t g;
    wr_t x;
    while (wr_seen.size() > 0) begin
      g = wr_seen.pop_front();
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL %s_extra_write: addr=%h data=%h, required no write", name, g.addr, g.data);
      end else begin
        x = exp_wr.pop_front();
        if (g.addr !== x.addr || g.data !== x.data) begin
          errors++;
          $display("FAIL %s_write: addr=%h data=%h, required %h %h", name, g.addr, g.data, x.addr, x.data);
        end
      end
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d outstanding, required 0", name, exp_wr.size());
    end
    exp_wr.delete();
    checks++;
    if (fail_count !== CNTW'(m_fc)) begin
      errors++;
      $display("FAIL %s_fail_count: %0d, required %0d", name, fail_count, m_fc);
    end
    checks++;
    if (log_overflow !== m_ovf) begin
      errors++;
      $display("FAIL %s_overflow: %b, required %b", name, log_overflow, m_ovf);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (cfifo_rdreq !== 1'b0 || rfifo_rdreq !== 1'b0 || mem_write !== 1'b0 || sc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: rdreq=%b%b write=%b sc_ready=%b, required 00 0 1", cfifo_rdreq, rfifo_rdreq, mem_write, sc_ready);
    end
    checks++;
    if (mem_address !== BASE || mem_writedata !== 16'h0000 || mem_byteenable !== 2'b11) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h be=%b, required %h 0000 11", mem_address, mem_writedata, mem_byteenable, BASE);
    end
    checks++;
    if (fail_count !== 16'h0000 || log_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: fail_count=%0d overflow=%b, required 0 0", fail_count, log_overflow);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || sc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: done=%b sc_ready=%b, required 1 1", done, sc_ready);
    end
  endtask

  task automatic test_pass();
    do_clear();
    push_vec(24'h00A5A5, 24'h00A5A5, 20'h00010);
    tick();
    checks++;
    if (last_pop_cycle !== cycle || sc_ready !== 1'b0) begin
      errors++;
      $display("FAIL pass_pop: pop_cycle=%0d sc_ready=%b, required %0d 0", last_pop_cycle, sc_ready, cycle);
    end
    tick();
    checks++;
    if (sc_ready !== 1'b1 || mem_write !== LOG_PASS) begin
      errors++;
      $display("FAIL pass_return: sc_ready=%b write=%b, required 1 %b", sc_ready, mem_write, LOG_PASS);
    end
    wait_done(20);
    check_writes("pass");
    // one FIFO holding data must not trigger a pop
    cq.push_back({24'h000777, 20'h00011});
    drive_fifo();
    tick();
    tick();
    checks++;
    if (cq.size() != 1) begin
      errors++;
      $display("FAIL single_fifo_pop: cq=%0d, required 1", cq.size());
    end
    rq.push_back(24'h000777);
    drive_fifo();
    wait_done(20);
    check_writes("single_fifo");
  endtask

  task automatic test_fail();
    int            p;
    logic [DW-1:0] ev[4];
    ev[0] = 16'h8000; ev[1] = 16'h0042; ev[2] = 16'h0012; ev[3] = 16'h3457;
    do_clear();
    push_vec(24'h123456, 24'h123457, 20'h00042);
    tick();
    p = cycle;
    wait_done(30);
    checks++;
    if (wr_seen.size() != 4) begin
      errors++;
      $display("FAIL fail_write_count: %0d, required 4", wr_seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_seen[k].addr !== BASE + AW'(k) || wr_seen[k].data !== ev[k] || wr_seen[k].cyc != p + 2 + k) begin
          errors++;
          $display("FAIL fail_word%0d: addr=%h data=%h cyc=%0d, required %h %h %0d", k, wr_seen[k].addr, wr_seen[k].data, wr_seen[k].cyc, BASE + AW'(k), ev[k], p + 2 + k);
        end
      end
    end
    checks++;
    if (cycle != p + 5) begin
      errors++;
      $display("FAIL fail_idle_cycle: %0d, required %0d", cycle - p, 5);
    end
    check_writes("fail");
  endtask

  task automatic test_mask();
    do_clear();
    push_vec(24'h123456, 24'h123457, 20'h00042);
    sc_cmd  = 5'b00001;
    sc_data = 24'hFFFFFE;
    m_mask  = 24'hFFFFFE;
    #1;
    checks++;
    if (cfifo_rdreq !== 1'b0 || rfifo_rdreq !== 1'b0) begin
      errors++;
      $display("FAIL mask_rdreq: rdreq=%b%b, required 00", cfifo_rdreq, rfifo_rdreq);
    end
    tick();
    sc_cmd  = 5'b00000;
    sc_data = 24'h000000;
    checks++;
    if (cq.size() != 1) begin
      errors++;
      $display("FAIL mask_no_pop: cq=%0d, required 1", cq.size());
    end
    wait_done(20);
    checks++;
    if (wr_seen.size() != (LOG_PASS ? 4 : 0)) begin
      errors++;
      $display("FAIL mask_writes: %0d, required %0d", wr_seen.size(), LOG_PASS ? 4 : 0);
    end
    check_writes("mask");
  endtask

  task automatic test_waitreq();
    do_clear();
    stall_addr = BASE + 20'h00001;
    stall_cnt  = 3;
    push_vec(24'h123456, 24'h123457, 20'h00042);
    wait_done(40);
    checks++;
    if (stall_cnt != 0 || wr_seen.size() != 4) begin
      errors++;
      $display("FAIL wait_record: stalls_left=%0d writes=%0d, required 0 4", stall_cnt, wr_seen.size());
    end else begin
      checks++;
      if (wr_seen[1].addr !== 20'h80001 || wr_seen[1].data !== 16'h0042 || wr_seen[1].cyc - wr_seen[0].cyc != 4) begin
        errors++;
        $display("FAIL wait_wr1: addr=%h data=%h gap=%0d, required 80001 0042 4", wr_seen[1].addr, wr_seen[1].data, wr_seen[1].cyc - wr_seen[0].cyc);
      end
    end
    stall_cnt = 0;
    push_vec(24'h000000, 24'hFFFFFF, 20'hABCDE);
    wait_done(30);
    checks++;
    if (wr_seen.size() < 5 || wr_seen[4].addr !== 20'h80004) begin
      errors++;
      $display("FAIL wait_ptr_advance: writes=%0d, required next record at 80004", wr_seen.size());
    end
    check_writes("waitreq");
  endtask

  task automatic test_overflow();
    do_clear();
    push_vec(24'h000001, 24'h000000, 20'h00001);
    push_vec(24'h000002, 24'h000000, 20'h00002);
    push_vec(24'h000004, 24'h000000, 20'h00003);
    wait_done(100);
    checks++;
    if (wr_seen.size() != 8 || log_overflow !== 1'b1 || fail_count !== 16'd3) begin
      errors++;
      $display("FAIL overflow_state: writes=%0d ovf=%b fc=%0d, required 8 1 3", wr_seen.size(), log_overflow, fail_count);
    end
    check_writes("overflow");
    do_clear();
    checks++;
    if (fail_count !== 16'd0 || log_overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_status: fc=%0d ovf=%b, required 0 0", fail_count, log_overflow);
    end
    push_vec(24'h000008, 24'h000000, 20'h00004);
    wait_done(30);
    checks++;
    if (wr_seen.size() == 0 || wr_seen[0].addr !== BASE) begin
      errors++;
      $display("FAIL clear_rewind: writes=%0d, required first at %h", wr_seen.size(), BASE);
    end
    check_writes("after_clear");
  endtask

  task automatic test_random();
    int            r;
    logic [SW-1:0] e;
    logic [SW-1:0] a;
    logic [SW-1:0] one;
    do_clear();
    rand_en = 1'b1;
    one = 24'h000001;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        e = SW'($urandom);
        a = ($urandom_range(0, 1) == 0) ? e : (e ^ (one << $urandom_range(0, 23)));
        push_vec(e, a, AW'($urandom));
      end else if (r == 6 && sc_ready === 1'b1) begin
        sc_cmd  = 5'b00001;
        sc_data = ($urandom_range(0, 1) == 0) ? 24'hFFFFFF : ~(one << $urandom_range(0, 23));
        m_mask  = sc_data;
        tick();
        sc_cmd  = 5'b00000;
      end else if (r == 7 && sc_ready === 1'b1 && $urandom_range(0, 3) == 0) begin
        clear = 1'b1;
        model_clear();
        tick();
        clear = 1'b0;
      end
      tick();
    end
    rand_en = 1'b0;
    wait_done(3000);
    check_writes("random");
  endtask

  task automatic test_reset_mid_write();
    int n;
    do_clear();
    push_vec(24'h123456, 24'h654321, 20'h00099);
    n = 0;
    while (wr_seen.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (mem_write !== 1'b1 || mem_address !== BASE + 20'h00002) begin
      errors++;
      $display("FAIL rst_wr2_reached: write=%b addr=%h, required 1 %h", mem_write, mem_address, BASE + 20'h00002);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || fail_count !== 16'd0 || mem_address !== BASE) begin
      errors++;
      $display("FAIL rst_async: write=%b fc=%0d addr=%h, required 0 0 %h", mem_write, fail_count, mem_address, BASE);
    end
    model_clear();
    exp_wr.delete();
    wr_seen.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (sc_ready !== 1'b1 || done !== 1'b1 || mem_write !== 1'b0 || fail_count !== 16'd0 || log_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: sc_ready=%b done=%b write=%b fc=%0d ovf=%b, required 1 1 0 0 0", sc_ready, done, mem_write, fail_count, log_overflow);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    clear           = 1'b0;
    sc_cmd          = 5'b00000;
    sc_data         = 24'h000000;
    mem_waitrequest = 1'b0;
    model_clear();
    drive_fifo();
    test_reset();
    test_pass();
    test_fail();
    test_mask();
    test_waitreq();
    test_overflow();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/check_engine.md
# check_engine

Result checker at the far end of the test pipeline: consumes the expected-result records that the stimulus generator pushes into CHECK_FIFO, pairs each with the DUT output word from RESULT_FIFO, compares them under the active output bitmask, and logs every mismatch as a 4-word record into SRAM through an Avalon-MM master write port. It also answers the stimulus block's `sc_cmd`/`sc_ready` side channel (bitmask setup), and exposes a saturating fail count and a log-overflow flag to the host.

## Interface
- `ADDR_WIDTH`, 20, SRAM word address width
- `DATA_WIDTH`, 16, SRAM data width; record layout assumes 16
- `STF_WIDTH`, 24, test-vector / result width
- `CHF_WIDTH`, STF_WIDTH+ADDR_WIDTH, check record: `[CHF_WIDTH-1 -: STF_WIDTH]` expected result, `[ADDR_WIDTH-1:0]` vector address tag
- `SCC_WIDTH`, 5; `SCD_WIDTH`, 24, side-channel command/data widths
- `LOG_BASE`, 20'h80000, first SRAM word of the log
- `LOG_RECORDS`, 4096, log capacity in records (4 words each)
- `CNT_WIDTH`, 16, fail counter width
---
- `clock` in 1, single clock
- `reset_n` in 1, asynchronous active-low reset
- `clear` in 1, pulse: reset counter, log pointer, overflow flag, bitmask
- `done` out 1, idle and both FIFOs empty
- `cfifo_data` in CHF_WIDTH; `cfifo_rdreq` out 1; `cfifo_rdempty` in 1, CHECK_FIFO, show-ahead
- `rfifo_data` in STF_WIDTH; `rfifo_rdreq` out 1; `rfifo_rdempty` in 1, RESULT_FIFO, show-ahead
- `sc_cmd` in SCC_WIDTH; `sc_data` in SCD_WIDTH; `sc_ready` out 1
- `mem_address` out ADDR_WIDTH; `mem_byteenable` out DATA_WIDTH/8 (all ones); `mem_write` out 1; `mem_writedata` out DATA_WIDTH; `mem_waitrequest` in 1
- `fail_count` out CNT_WIDTH; `log_overflow` out 1

## Operation
- States: IDLE, COMPARE, WR0, WR1, WR2, WR3.
- IDLE: `sc_ready`=1. If `clear`: apply clear, nothing else this cycle. Else if `sc_cmd`==SC_CMD_BITMASK (5'b00001): latch `sc_data` into bitmask, no pop. Else if both FIFOs non-empty: assert both rdreq in the same cycle, latch expected, tag, actual; go COMPARE.
- COMPARE: `mism = (actual ^ expected) & bitmask`. If `mism`≠0: `fail_count` +1 (saturating at all-ones). If a record is to be logged (see Configuration) and the log is not full: go WR0. If the log is full: set `log_overflow` and return to IDLE. Otherwise return to IDLE.
- WRn: `mem_write`=1, `mem_address` = log_ptr+n. Advance on `~mem_waitrequest`. After WR3 is accepted: log_ptr += 4; go IDLE.
- Record words:
  - w0 = {fail, 11'b0, tag[19:16]}
  - w1 = tag[15:0]
  - w2 = {8'b0, actual[23:16]}
  - w3 = actual[15:0]
  - `fail`=1 for a mismatch.
- Log full when log_ptr == LOG_BASE + 4*LOG_RECORDS; no wrap; pointer holds.
- `clear` is honoured only in IDLE and ignored in other states. It sets:
  - `fail_count` = 0
  - log_ptr = LOG_BASE
  - `log_overflow` = 0
  - bitmask = all ones
- `rdreq` is never asserted with the corresponding empty flag high; the two FIFOs are always popped together.

## Timing
- Reset: state IDLE, bitmask all ones, log_ptr LOG_BASE, and the following outputs:
  - `cfifo_rdreq`/`rfifo_rdreq`/`mem_write` 0
  - `mem_address` LOG_BASE
  - `mem_writedata` 0
  - `fail_count` 0
  - `log_overflow` 0
  - `sc_ready` 1
- Pop in cycle N; COMPARE in N+1; with no waitrequest, WR0..WR3 in N+2..N+5; IDLE in N+6.
- Throughput with no wait states: passing vector every 2 cycles; logged vector every 6 cycles.
- `mem_write`/`mem_address`/`mem_writedata` are held stable while `mem_waitrequest`=1.
- Reset asserted mid-write drops `mem_write` immediately (async). No other abort path exists.
- `sc_ready`, `rdreq`, and `done` are combinational from state and inputs. All other outputs are registered.

## Configuration
- `CHK_LOG_PASS_EN` defined: passing vectors are also logged, with `fail`=0. They consume log space but do not count in `fail_count`.
- Not defined: only mismatches are logged. The COMPARE→IDLE path is taken for every pass.

## Structure
- Shared package `chk_pkg` holds:
  - SC_CMD_IDLE/SC_CMD_BITMASK codes, shared with the stimulus block
  - state encoding
  - record word indices (REC_W0..REC_W3, REC_WORDS=4)
  - the fail-flag bit position
- Single module; the 4-word serializer is too small for a separate sub-module.

## Test plan
- Bitmask all ones; expected 24'h00A5A5, actual 24'h00A5A5, tag 20'h00010 -> no `mem_write`, `fail_count` stays 0, back to IDLE after 2 cycles.
- Expected 24'h123456, actual 24'h123457, tag 20'h00042 -> 4 writes at 20'h80000..80003: 16'h8000, 16'h0042, 16'h0012, 16'h3457; `fail_count`=1.
- Bitmask set via `sc_cmd`=1 with `sc_data`=24'hFFFFFE, then the vector from the previous case -> no write, `fail_count` 0. A bitmask command and a non-empty FIFO in the same cycle -> no pop that cycle.
- `mem_waitrequest` held high 3 cycles during WR1 -> address 20'h80001 and data held stable, record completes, pointer advances to 20'h80004.
- LOG_RECORDS=2, three failing vectors -> exactly 8 writes, `log_overflow`=1, `fail_count`=3. Then `clear` -> counter 0, flag 0, next record lands at 20'h80000.
- Reset asserted during WR2 -> `mem_write` 0 immediately. After release: IDLE, `fail_count` 0, `sc_ready` 1.
